// File: rtl/uart_tx.sv
// UART transmitter, 16x oversampled.
// Sends one start bit (0), then DBIT data bits LSB first, then a stop period of SB_TICK s_ticks
// with the line high. All outputs are registered.
//
// Parameters:
//   DBIT         data bits per frame (5..8)
//   SB_TICK      stop length in s_tick units (16 = 1, 24 = 1.5, 32 = 2 stop bits)
// Ports:
//   clk          system clock, rising edge
//   reset        asynchronous, active-high reset
//   s_tick       16x baud enable pulse, one clk wide
//   tx_start     level-sampled send request, honoured only in IDLE
//   din          byte to send; bits DBIT-1..0 are used, captured at acceptance
//   tx           serial line, idle high
//   tx_busy      high in every state except IDLE
//   tx_done_tick one-clk pulse when the stop period completes
module uart_tx #(
    parameter int DBIT    = 8,
    parameter int SB_TICK = 16
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       s_tick,
    input  logic       tx_start,
    input  logic [7:0] din,
    output logic       tx,
    output logic       tx_busy,
    output logic       tx_done_tick
);

    typedef enum logic [1:0] {IDLE, START, DATA, STOP} state_t;

    localparam logic [4:0] S_BIT_LAST  = 5'd15;
    localparam logic [4:0] S_STOP_LAST = 5'(SB_TICK - 1);
    localparam logic [2:0] N_LAST      = 3'(DBIT - 1);

    state_t     state;
    logic [4:0] s;      // s_ticks elapsed within the current bit
    logic [2:0] n;      // data bit index
    logic [7:0] b;      // shift register, b[0] is the bit on the line during DATA

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state        <= IDLE;
            s            <= 5'd0;
            n            <= 3'd0;
            b            <= 8'd0;
            tx           <= 1'b1;
            tx_busy      <= 1'b0;
            tx_done_tick <= 1'b0;
        end else begin
            tx_done_tick <= 1'b0;
            case (state)
                IDLE: begin
                    // A request seen during the done pulse waits one clk, guaranteeing an
                    // idle cycle between back-to-back frames.
                    if (tx_start && !tx_done_tick) begin
                        b       <= din;
                        s       <= 5'd0;
                        tx      <= 1'b0;
                        tx_busy <= 1'b1;
                        state   <= START;
                    end
                end
                START: begin
                    if (s_tick) begin
                        if (s == S_BIT_LAST) begin
                            s     <= 5'd0;
                            n     <= 3'd0;
                            tx    <= b[0];
                            state <= DATA;
                        end else begin
                            s <= s + 5'd1;
                        end
                    end
                end
                DATA: begin
                    if (s_tick) begin
                        if (s == S_BIT_LAST) begin
                            s <= 5'd0;
                            b <= {1'b0, b[7:1]};
                            if (n == N_LAST) begin
                                tx    <= 1'b1;
                                state <= STOP;
                            end else begin
                                n  <= n + 3'd1;
                                tx <= b[1];   // next bit after the shift
                            end
                        end else begin
                            s <= s + 5'd1;
                        end
                    end
                end
                STOP: begin
                    if (s_tick) begin
                        if (s == S_STOP_LAST) begin
                            s            <= 5'd0;
                            tx_busy      <= 1'b0;
                            tx_done_tick <= 1'b1;
                            state        <= IDLE;
                        end else begin
                            s <= s + 5'd1;
                        end
                    end
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_uart_tx.sv
// Self-checking bench for uart_tx: a default instance (8 data bits, 1 stop bit) and a
// DBIT=7 / SB_TICK=32 instance. A monitor counts consumed s_ticks per frame, checks the line at
// the first and last tick of every bit against frames queued by the stimulus, and checks the
// frame length at tx_done_tick.
module tb_uart_tx;

    logic       clk;
    logic       reset;
    logic       s_tick;
    logic       start_a;
    logic       start_b;
    logic [7:0] din;
    logic       tx_a, busy_a, done_a;
    logic       tx_b, busy_b, done_b;

    uart_tx dut_a (
        .clk          (clk),
        .reset        (reset),
        .s_tick       (s_tick),
        .tx_start     (start_a),
        .din          (din),
        .tx           (tx_a),
        .tx_busy      (busy_a),
        .tx_done_tick (done_a)
    );

    uart_tx #(.DBIT(7), .SB_TICK(32)) dut_b (
        .clk          (clk),
        .reset        (reset),
        .s_tick       (s_tick),
        .tx_start     (start_b),
        .din          (din),
        .tx           (tx_b),
        .tx_busy      (busy_b),
        .tx_done_tick (done_b)
    );

    // Selected DUT, seen by the monitor and the main sequence.
    logic sel;
    logic mtx, mbusy, mdone;
    assign mtx   = sel ? tx_b   : tx_a;
    assign mbusy = sel ? busy_b : busy_a;
    assign mdone = sel ? done_b : done_a;

    int n_checks = 0;
    int n_pass   = 0;

    function automatic void check(input string name, input logic [31:0] act,
                                  input logic [31:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
    endfunction

    typedef struct {
        logic [7:0] data;
        int         dbit;
        int         sbt;
    } frame_t;

    frame_t frame_q[$];

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // s_tick generator: fixed period or random gaps, changed just after the rising edge.
    int tick_per  = 4;
    bit tick_rand = 1'b0;
    bit tick_en   = 1'b1;
    initial begin
        int gap;
        gap    = 0;
        s_tick = 1'b0;
        forever begin
            @(posedge clk);
            #2;
            if (!tick_en) begin
                s_tick = 1'b0;
            end else if (gap == 0) begin
                s_tick = 1'b1;
                gap    = tick_rand ? int'($urandom_range(7, 0)) : tick_per - 1;
            end else begin
                s_tick = 1'b0;
                gap--;
            end
        end
    end

    // Monitor: pops the expected frame at the start bit, checks it, aborts on reset.
    initial begin
        frame_t f;
        int ticks, last, steps, k, off;
        logic ebit;
        forever begin
            @(negedge clk);
            if (reset || mtx !== 1'b0) continue;
            check("frame queued", frame_q.size() != 0, 1);
            if (frame_q.size() == 0) begin
                while (mtx === 1'b0) @(negedge clk);
                continue;
            end
            f     = frame_q.pop_front();
            ticks = 0;
            last  = -1;
            steps = 0;
            forever begin
                if (reset) break;
                if (ticks != last) begin
                    last = ticks;
                    if (ticks < 16 * (f.dbit + 1)) begin
                        k   = ticks / 16;
                        off = ticks % 16;
                        if (off == 0 || off == 15) begin
                            ebit = (k == 0) ? 1'b0 : f.data[k-1];
                            check($sformatf("tx bit%0d tick%0d", k, off), mtx, ebit);
                        end
                    end else if (ticks < 16 * (f.dbit + 1) + f.sbt) begin
                        off = ticks - 16 * (f.dbit + 1);
                        if (off == 0 || off == f.sbt - 1)
                            check($sformatf("stop tick%0d", off), mtx, 1'b1);
                    end
                end
                if (mdone) begin
                    check("frame length in ticks", ticks, 16 * (f.dbit + 1) + f.sbt);
                    check("busy low with done", mbusy, 1'b0);
                    break;
                end
                if (steps > 20000) begin
                    check("frame clk budget", steps, 20000);
                    break;
                end
                if (s_tick) ticks++;
                steps++;
                @(negedge clk);
            end
        end
    end

    task automatic start_frame(input logic [7:0] d, input logic [7:0] expd);
        @(negedge clk);
        din = d;
        if (sel) begin
            start_b = 1'b1;
            frame_q.push_back('{data: expd, dbit: 7, sbt: 32});
        end else begin
            start_a = 1'b1;
            frame_q.push_back('{data: expd, dbit: 8, sbt: 16});
        end
        @(negedge clk);
        start_a = 1'b0;
        start_b = 1'b0;
        check("busy after accept", mbusy, 1'b1);
    endtask

    task automatic wait_done(input int budget);
        bit ok;
        ok = 1'b0;
        for (int i = 0; i < budget; i++) begin
            @(negedge clk);
            if (mdone === 1'b1) begin
                ok = 1'b1;
                break;
            end
        end
        check("done within budget", ok, 1'b1);
    endtask

    typedef struct {
        logic [7:0] din;
        logic [7:0] din_late;   // driven one cycle after acceptance when late is set
        bit         late;
        int         per;
        bit         rnd;
        int         bit_clks;   // expected clk length of data bit 0 (0: not measured)
        logic [7:0] exp;        // expected transmitted byte
    } vec_t;

    initial begin
        vec_t vecs[6];
        int   cnt;
        int   bad;

        vecs[0] = '{8'h55, 8'h00, 1'b0, 4, 1'b0, 64, 8'h55};
        vecs[1] = '{8'hA3, 8'hFF, 1'b1, 4, 1'b0, 0,  8'hA3};
        vecs[2] = '{8'h00, 8'h00, 1'b0, 1, 1'b0, 0,  8'h00};
        vecs[3] = '{8'hFF, 8'h00, 1'b0, 2, 1'b0, 0,  8'hFF};
        vecs[4] = '{8'h81, 8'h7E, 1'b1, 1, 1'b1, 0,  8'h81};
        vecs[5] = '{8'h3C, 8'h00, 1'b0, 3, 1'b0, 0,  8'h3C};

        sel     = 1'b0;
        start_a = 1'b0;
        start_b = 1'b0;
        din     = 8'h00;
        reset   = 1'b1;
        repeat (2) @(negedge clk);
        check("reset tx_a", tx_a, 1'b1);
        check("reset busy_a", busy_a, 1'b0);
        check("reset done_a", done_a, 1'b0);
        check("reset tx_b", tx_b, 1'b1);
        check("reset busy_b", busy_b, 1'b0);
        reset = 1'b0;

        // Table-driven single frames on the default instance.
        foreach (vecs[i]) begin
            tick_per  = vecs[i].per;
            tick_rand = vecs[i].rnd;
            start_frame(vecs[i].din, vecs[i].exp);
            if (vecs[i].late) din = vecs[i].din_late;
            if (vecs[i].bit_clks != 0) begin
                cnt = 0;
                while (mtx === 1'b0 && cnt < 2000) begin
                    @(negedge clk);
                    cnt++;
                end
                cnt = 0;
                while (mtx === 1'b1 && cnt < 2000) begin
                    @(negedge clk);
                    cnt++;
                end
                check("data bit0 clk length", cnt, vecs[i].bit_clks);
            end
            wait_done(20000);
            @(negedge clk);
            check("done is one clk", mdone, 1'b0);
            check("idle busy", mbusy, 1'b0);
            check("idle tx", mtx, 1'b1);
        end

        // tx_start held high: three back-to-back frames with one idle clk between them.
        tick_per  = 2;
        tick_rand = 1'b0;
        @(negedge clk);
        din     = 8'hC5;
        start_a = 1'b1;
        repeat (3) frame_q.push_back('{data: 8'hC5, dbit: 8, sbt: 16});
        for (int f = 0; f < 3; f++) begin
            wait_done(20000);
            check("busy falls with done", mbusy, 1'b0);
            if (f < 2) begin
                @(negedge clk);
                check("idle gap clk", mbusy, 1'b0);
                @(negedge clk);
                check("busy after gap", mbusy, 1'b1);
                if (f == 1) start_a = 1'b0;
            end
        end
        repeat (2) @(negedge clk);
        check("no extra frame", mbusy, 1'b0);

        // Asynchronous reset during data bit 3, then a frame on the first edge after release.
        start_frame(8'h00, 8'h00);
        repeat (140) @(negedge clk);
        check("tx low in data bit3", mtx, 1'b0);
        #2 reset = 1'b1;
        #1;
        check("async reset tx", mtx, 1'b1);
        check("async reset busy", mbusy, 1'b0);
        bad = 0;
        repeat (3) begin
            @(negedge clk);
            if (mdone !== 1'b0 || mtx !== 1'b1) bad++;
        end
        check("no done under reset", bad, 0);
        reset   = 1'b0;
        din     = 8'h0F;
        start_a = 1'b1;
        frame_q.push_back('{data: 8'h0F, dbit: 8, sbt: 16});
        @(negedge clk);
        start_a = 1'b0;
        check("accept on first edge after reset", mbusy, 1'b1);
        wait_done(20000);

        // DBIT=7, SB_TICK=32 with irregular tick gaps; bit 7 of din must be ignored.
        @(negedge clk);
        sel       = 1'b1;
        tick_rand = 1'b1;
        start_frame(8'h5A, 8'h5A);
        wait_done(20000);
        start_frame(8'hB3, 8'hB3);
        wait_done(20000);
        start_frame(8'h7F, 8'h7F);
        wait_done(20000);
        @(negedge clk);
        check("dbit7 idle tx", mtx, 1'b1);

        // Tick stall during START: the line and FSM hold, then the frame resumes.
        sel       = 1'b0;
        tick_rand = 1'b0;
        tick_per  = 3;
        start_frame(8'h96, 8'h96);
        repeat (10) @(negedge clk);
        tick_en = 1'b0;
        bad     = 0;
        repeat (1000) begin
            @(negedge clk);
            if (mtx !== 1'b0 || mbusy !== 1'b1 || mdone !== 1'b0) bad++;
        end
        check("hold without ticks", bad, 0);
        tick_en = 1'b1;
        wait_done(20000);

        repeat (2) @(negedge clk);
        check("scoreboard drained", frame_q.size(), 0);
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

endmodule

// File: doc/uart_tx.md
UART_TX -- requirements
Module: uart_tx

Interface
- REQ-001 Parameter DBIT, default 8: data bits per frame; legal values 5 to 8.
- REQ-002 Parameter SB_TICK, default 16: stop-bit length in s_tick units; 16 gives 1 stop bit, 24 gives 1.5, 32 gives 2.
- REQ-003 Port clk, input, 1: single system clock, rising edge.
- REQ-004 Port reset, input, 1: asynchronous, active-high reset.
- REQ-005 Port s_tick, input, 1: 16x-oversampling enable pulse from the baud rate generator; one clk wide.
- REQ-006 Port tx_start, input, 1: request to send din; level-sampled on clk.
- REQ-007 Port din, input, 8: transmit byte; bits DBIT-1..0 are used.
- REQ-008 Port tx, output, 1: serial line, registered, idle high.
- REQ-009 Port tx_busy, output, 1: high in every state except IDLE.
- REQ-010 Port tx_done_tick, output, 1: one-clk pulse at end of the stop bit.

Function
- REQ-011 The FSM SHALL have exactly four states: IDLE, START, DATA and STOP.
- REQ-012 The block SHALL contain a tick counter s (5 bits), a bit counter n (3 bits), a shift register b (8 bits) and a tx register.
- REQ-013 In IDLE with tx_start=1 at a clk edge, the block SHALL load b<=din, s<=0 and move to START.
- REQ-014 tx_start SHALL be ignored in every state other than IDLE; a held-high tx_start SHALL start a new frame on the first IDLE cycle.
- REQ-015 din SHALL be sampled only at acceptance; later changes to din SHALL NOT affect the frame in flight.
- REQ-016 tx SHALL be 0 throughout START, b[0] throughout DATA and 1 in STOP and IDLE; data SHALL be sent LSB first.
- REQ-017 The counters s and n SHALL change only on cycles with s_tick=1; the FSM SHALL hold when s_tick=0.
- REQ-018 START: on the s_tick with s=15, the block SHALL set s<=0, n<=0 and go to DATA; otherwise s<=s+1.
- REQ-019 DATA: on the s_tick with s=15, the block SHALL set s<=0 and shift b right by one; when n=DBIT-1 it SHALL go to STOP, else n<=n+1.
- REQ-020 STOP: on the s_tick with s=SB_TICK-1, the block SHALL go to IDLE and assert tx_done_tick for that single clk cycle.
- REQ-021 Frame length SHALL be exactly 16*(1+DBIT)+SB_TICK s_tick pulses from acceptance to tx_done_tick.
- REQ-022 tx_busy SHALL rise the cycle after acceptance and fall in the same cycle tx_done_tick is high (registered next state).
- REQ-023 A tx_start in the tx_done_tick cycle SHALL be ignored; acceptance occurs on the following cycle (IDLE), giving one idle clk minimum between frames.
- REQ-024 The tick counter SHALL NOT overflow: s never exceeds max(15, SB_TICK-1).

Reset
- REQ-025 reset=1 SHALL immediately force state=IDLE, tx=1, s=0, n=0, b=0, tx_busy=0 and tx_done_tick=0, independent of clk.
- REQ-026 Reset asserted mid-frame SHALL abort the frame with no tx_done_tick, and tx SHALL return high asynchronously.
- REQ-027 After reset deassertion the block SHALL accept tx_start on the first clk edge.

Verification
- REQ-028 Scenario 1: reset, s_tick every 4 clk, din=0x55, tx_start 1 clk -> tx sequence 0,1,0,1,0,1,0,1,0,1 (start, LSB first, stop) with each bit 64 clk, and tx_done_tick after 160 ticks.
- REQ-029 Scenario 2: din=0xA3, then din changed to 0xFF one cycle after acceptance -> transmitted data bits 1,1,0,0,0,1,0,1 (0xA3).
- REQ-030 Scenario 3: tx_start held high for 3 frames -> 3 back-to-back frames, each tx_done_tick followed by exactly one IDLE clk before tx_busy rises again.
- REQ-031 Scenario 4: reset pulsed during DATA bit 3 -> tx=1 immediately, tx_busy=0, no tx_done_tick; next tx_start=0x0F transmits correctly.
- REQ-032 Scenario 5: SB_TICK=32, DBIT=7 -> stop high for 32 ticks; total frame 160 ticks; s_tick gaps of irregular length do not alter bit values.
- REQ-033 Scenario 6: s_tick held 0 for 1000 clk mid-START -> tx stays 0 and the FSM holds; frame resumes correctly when ticks resume.
